// File: rtl/gpio_ctrl_pkg.sv
// Shared register map and request FSM encoding for the GPIO controller.
package gpio_ctrl_pkg;

    localparam int unsigned ADDR_DATA_OUT   = 0;
    localparam int unsigned ADDR_DIR        = 1;
    localparam int unsigned ADDR_DATA_IN    = 2;
    localparam int unsigned ADDR_RISE_EN    = 3;
    localparam int unsigned ADDR_FALL_EN    = 4;
    localparam int unsigned ADDR_IRQ_STATUS = 5;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

endpackage

// File: rtl/gpio_ctrl_sync.sv
// Two-flop synchronizer for asynchronous pin inputs, reset to 0.
module gpio_ctrl_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments make the two stages shift on the same edge
    // instead of collapsing into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: direction/output registers, synchronized
// readback and sticky W1C edge interrupts behind a valid/ready request port.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    inout  wire  [WIDTH-1:0]  gpio_pin,
    output logic              irq
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c_mask;
    logic             accept;

    gpio_ctrl_sync #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gpio_pin),
        .q_o   (data_in)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpio_pin[i] = dir_q[i] ? data_out_q[i] : 1'bz;
    end

    assign rise   = data_in & ~prev_q;
    assign fall   = ~data_in & prev_q;
    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        data_out_d  = data_out_q;
        dir_d       = dir_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        w1c_mask    = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (accept) begin
            case (req_addr)
                ADDR_W'(ADDR_DATA_OUT):
                    if (req_write) data_out_d = req_wdata;
                    else           rsp_rdata_d = data_out_q;
                ADDR_W'(ADDR_DIR):
                    if (req_write) dir_d = req_wdata;
                    else           rsp_rdata_d = dir_q;
                ADDR_W'(ADDR_DATA_IN):
                    if (!req_write) rsp_rdata_d = data_in;
                ADDR_W'(ADDR_RISE_EN):
                    if (req_write) rise_en_d = req_wdata;
                    else           rsp_rdata_d = rise_en_q;
                ADDR_W'(ADDR_FALL_EN):
                    if (req_write) fall_en_d = req_wdata;
                    else           rsp_rdata_d = fall_en_q;
                ADDR_W'(ADDR_IRQ_STATUS):
                    if (req_write) w1c_mask = req_wdata;
                    else           rsp_rdata_d = irq_status_q;
                default:
                    rsp_err_d = 1'b1;
            endcase
        end
        // A new event in the same cycle as a W1C keeps the bit set.
        irq_status_d = (irq_status_q & ~w1c_mask)
                     | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_out_q   <= '0;
            dir_q        <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            prev_q       <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            prev_q       <= data_in;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign irq       = |irq_status_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: table-driven register access, directed
// interrupt/reset sequences and a randomized run against a pin-history model.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    wire  [7:0]  gpio_pin;
    logic        irq;

    // Pin driver on the far side: drives every pin the controller is not driving.
    logic [7:0]  tb_val;
    logic [7:0]  m_out, m_dir, m_rise, m_fall, m_status;
    logic [7:0]  h0, h1, h2;          // pin value at the last three edges, newest first
    logic        m_idle, m_rsp_valid, m_err;
    logic [7:0]  m_rdata;
    wire  [7:0]  tb_en = ~m_dir;

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign gpio_pin[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_ctrl #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .gpio_pin  (gpio_pin),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic reset_model();
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
        h0 = '0; h1 = '0; h2 = '0;
        m_idle = 1'b1; m_rsp_valid = 1'b0; m_rdata = '0; m_err = 1'b0;
    endtask

    // Advance one clock edge and move the model along, then settle 1 time unit.
    task automatic tick();
        logic [7:0] pin_now, rise, fall, rd, clr, n_out, n_dir, n_rise, n_fall;
        logic       acc, mapped;
        pin_now = (m_dir & m_out) | (~m_dir & tb_val);
        rise    = h1 & ~h2;
        fall    = ~h1 & h2;
        acc     = req_valid && m_idle;
        rd = '0; clr = '0; mapped = 1'b1;
        n_out = m_out; n_dir = m_dir; n_rise = m_rise; n_fall = m_fall;
        if (acc) begin
            case (req_addr)
                4'h0: if (req_write) n_out  = req_wdata; else rd = m_out;
                4'h1: if (req_write) n_dir  = req_wdata; else rd = m_dir;
                4'h2: if (!req_write) rd = h1;
                4'h3: if (req_write) n_rise = req_wdata; else rd = m_rise;
                4'h4: if (req_write) n_fall = req_wdata; else rd = m_fall;
                4'h5: if (req_write) clr    = req_wdata; else rd = m_status;
                default: mapped = 1'b0;
            endcase
        end
        @(posedge clk);
        m_status = (m_status & ~clr) | (rise & m_rise) | (fall & m_fall);
        m_out = n_out; m_dir = n_dir; m_rise = n_rise; m_fall = n_fall;
        h2 = h1; h1 = h0; h0 = pin_now;
        m_rsp_valid = acc;
        m_rdata     = (acc && mapped) ? rd : 8'h00;
        m_err       = acc && !mapped;
        m_idle      = !acc;
        #1;
    endtask

    task automatic check_outputs();
        check("m_req_ready", req_ready, m_idle);
        check("m_rsp_valid", rsp_valid, m_rsp_valid);
        check("m_rsp_rdata", rsp_rdata, m_rdata);
        check("m_rsp_err",   rsp_err,   m_err);
        check("m_irq",       irq,       |m_status);
        check("m_pins",      gpio_pin,  (m_dir & m_out) | (~m_dir & tb_val));
    endtask

    task automatic do_req(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output logic err, output logic irq_a);
        int n = 0;
        while (req_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        check("rsp_valid_strobe", rsp_valid, 1);
        rdata = rsp_rdata; err = rsp_err; irq_a = irq;
        check_outputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       er, ia;
        int         pulses;

        vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 4'h1, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 4'h2, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 4'h3, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 4'h4, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 4'h5, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 4'h7, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{1'b1, 4'h6, 8'hFF, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 4'hF, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{1'b1, 4'h1, 8'hF0, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 8'hA5, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 4'h1, 8'h00, 8'hF0, 1'b0};
        vecs[12] = '{1'b0, 4'h0, 8'h00, 8'hA5, 1'b0};
        vecs[13] = '{1'b1, 4'h2, 8'hFF, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 4'h2, 8'h00, 8'hA0, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        tb_val = 8'h00;
        reset_model();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_irq",       irq,       0);
        // Controller must float every pin: the far side sees its own values.
        tb_val = 8'h5A; #1;
        check("rst_pins_5a", gpio_pin, 8'h5A);
        tb_val = 8'hA5; #1;
        check("rst_pins_a5", gpio_pin, 8'hA5);
        tb_val = 8'h00;
        repeat (3) tick();

        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, ia);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i),  er, vecs[i].exp_err);
        end

        // Upper nibble driven by the controller, lower nibble by the far side.
        tb_val = 8'h03;
        tick();
        check("pins_a3", gpio_pin, 8'hA3);
        repeat (2) tick();
        do_req(1'b0, 4'h2, 8'h00, rd, er, ia);
        check("data_in_a3", rd, 8'hA3);

        // Rising edge on pin0: status and irq appear two edges after sampling.
        tb_val = 8'h02;
        repeat (3) tick();
        do_req(1'b1, 4'h3, 8'h01, rd, er, ia);
        tb_val = 8'h03;
        tick();
        check("rise_irq_k",   irq, 0);
        tick();
        check("rise_irq_k1",  irq, 0);
        tick();
        check("rise_irq_k2",  irq, 1);
        do_req(1'b0, 4'h5, 8'h00, rd, er, ia);
        check("rise_status", rd, 8'h01);
        do_req(1'b1, 4'h5, 8'h01, rd, er, ia);
        check("w1c_irq_after", ia, 0);
        do_req(1'b0, 4'h5, 8'h00, rd, er, ia);
        check("w1c_status", rd, 8'h00);

        // Falling edge on pin1 whose status set lands on the W1C accept edge.
        do_req(1'b1, 4'h4, 8'h02, rd, er, ia);
        tb_val = 8'h01;
        tick();
        tick();
        do_req(1'b1, 4'h5, 8'h02, rd, er, ia);
        check("set_wins_irq", ia, 1);
        do_req(1'b0, 4'h5, 8'h00, rd, er, ia);
        check("set_wins_status", rd, 8'h02);
        do_req(1'b1, 4'h5, 8'h02, rd, er, ia);
        do_req(1'b0, 4'h5, 8'h00, rd, er, ia);
        check("fall_cleared", rd, 8'h00);

        // req_valid held for 6 cycles: ready alternates, 3 responses.
        pulses = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid === 1'b1) pulses++;
            check($sformatf("bb_ready%0d", i), req_ready, (i % 2 == 0) ? 0 : 1);
        end
        req_valid = 1'b0;
        check("bb_pulses", pulses, 3);

        // Reset while a response is being presented.
        do_req(1'b1, 4'h1, 8'h3C, rd, er, ia);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h1;
        tick();
        req_valid = 1'b0;
        check("mid_rsp_valid", rsp_valid, 1);
        #1 rst_n = 1'b0;
        reset_model();
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_ready",     req_ready, 1);
        check("mid_rst_rdata",     rsp_rdata, 0);
        check("mid_rst_pins",      gpio_pin,  tb_val);
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_req(1'b0, 4'h1, 8'h00, rd, er, ia);
        check("post_rst_dir", rd, 8'h00);
        do_req(1'b0, 4'h0, 8'h00, rd, er, ia);
        check("post_rst_out", rd, 8'h00);

        // Randomized traffic and pin activity against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) tb_val = 8'($urandom);
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 4'($urandom_range(0, 7));
            req_wdata = 8'($urandom);
            tick();
            check_outputs();
        end
        req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
